// File: rtl/gci_std_display_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gci_std_display_vram_arbiter
// Purpose  : Grants the single VRAM port to one of three display requesters
//            (0 = clear, 1 = character, 2 = bus) in round-robin order. It
//            forwards the owner's transfers to the VRAM side and routes read
//            data back to the owner.
// Ports    : iCLOCK / inRESET (async, active-low) / iRESET_SYNC (sync, high)
//            iRQ_*  : per-requester valid, rw, address slice, RGB slice, finish
//            oRQ_*  : one-hot grant and per-requester busy
//            oRD_*  : read-return valid (owner's bit) and data
//            oIF_* / iIF_* : VRAM-side request/ack/finish handshake, transfer
//            strobe, address and RGB, break, busy and read return
// Config   : GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN - when defined, a grant
//            is released after P_BURST_MAX accepted transfers.
// Revision : 1.0 - initial release
// ============================================================================
module gci_std_display_vram_arbiter #(
  parameter int unsigned P_MEM_ADDR_N = 23,
  parameter int unsigned P_BURST_MAX  = 16
) (
  input  logic                      iCLOCK,
  input  logic                      inRESET,
  input  logic                      iRESET_SYNC,
  input  logic [2:0]                iRQ_VALID,
  input  logic [2:0]                iRQ_RW,
  input  logic [3*P_MEM_ADDR_N-1:0] iRQ_ADDR,
  input  logic [71:0]               iRQ_DATA,
  input  logic [2:0]                iRQ_FINISH,
  output logic [2:0]                oRQ_GRANT,
  output logic [2:0]                oRQ_BUSY,
  output logic [2:0]                oRD_VALID,
  output logic [31:0]               oRD_DATA,
  output logic                      oIF_REQ,
  input  logic                      iIF_ACK,
  output logic                      oIF_FINISH,
  input  logic                      iIF_BREAK,
  input  logic                      iIF_BUSY,
  output logic                      oIF_ENA,
  output logic                      oIF_RW,
  output logic [P_MEM_ADDR_N-1:0]   oIF_ADDR,
  output logic [7:0]                oIF_R,
  output logic [7:0]                oIF_G,
  output logic [7:0]                oIF_B,
  input  logic                      iIF_VALID,
  input  logic [31:0]               iIF_DATA
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WORK      = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_END       = 3'd4
  } state_t;

  // The transfer counter is 5 bits wide, so only caps of 1..31 are meaningful.
  if (P_BURST_MAX < 1 || P_BURST_MAX > 31) begin : g_burst_max_unsupported
  end

  state_t      state_q;
  logic [2:0]  grant_q;
  logic [1:0]  owner_q;
  logic [1:0]  last_q;
  logic        brk_pend_q;
  logic [2:0]  rd_valid_q;
  logic [31:0] rd_data_q;
`ifdef GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN
  logic [4:0]  cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: first valid requester starting at (last owner + 1) mod 3
  // --------------------------------------------------------------------------
  logic [1:0] rr_owner_d;
  logic       rr_hit;
  logic [1:0] cand;

  always_comb begin
    rr_owner_d = 2'd0;
    rr_hit     = 1'b0;
    cand       = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((32'(last_q) + 32'(k)) % 32'd3);
      if (!rr_hit && iRQ_VALID[cand]) begin
        rr_owner_d = cand;
        rr_hit     = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Owner's request slice
  // --------------------------------------------------------------------------
  logic                    owner_valid;
  logic                    owner_rw;
  logic                    owner_finish;
  logic [P_MEM_ADDR_N-1:0] owner_addr;
  logic [23:0]             owner_rgb;

  assign owner_valid  = iRQ_VALID[owner_q];
  assign owner_rw     = iRQ_RW[owner_q];
  assign owner_finish = iRQ_FINISH[owner_q];
  assign owner_addr   = iRQ_ADDR[owner_q*P_MEM_ADDR_N +: P_MEM_ADDR_N];
  assign owner_rgb    = iRQ_DATA[owner_q*24 +: 24];

  logic burst_hit;
`ifdef GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN
  assign burst_hit = (cnt_q == 5'(P_BURST_MAX));
`else
  assign burst_hit = 1'b0;
`endif

  // Release conditions win over a transfer in the same cycle. A break seen
  // while a read was outstanding is remembered and honoured on return to WORK.
  logic end_req;
  logic accept;

  assign end_req = (state_q == ST_WORK) &&
                   (iIF_BREAK || brk_pend_q || owner_finish || burst_hit);
  assign accept  = (state_q == ST_WORK) && !end_req && owner_valid && !iIF_BUSY;

  // --------------------------------------------------------------------------
  // Outputs: transfer path is combinational so writes stream at one per cycle;
  // address and RGB are zeroed when nothing is accepted so idle requesters
  // never show up on the VRAM side.
  // --------------------------------------------------------------------------
  assign oRQ_GRANT  = grant_q;
  assign oRQ_BUSY   = ~(grant_q & {3{accept}});
  assign oRD_VALID  = rd_valid_q;
  assign oRD_DATA   = rd_data_q;
  assign oIF_REQ    = (state_q == ST_REQ);
  assign oIF_FINISH = (state_q == ST_END);
  assign oIF_ENA    = accept;
  assign oIF_RW     = accept & owner_rw;
  assign oIF_ADDR   = accept ? owner_addr : '0;
  assign oIF_R      = accept ? owner_rgb[23:16] : 8'd0;
  assign oIF_G      = accept ? owner_rgb[15:8]  : 8'd0;
  assign oIF_B      = accept ? owner_rgb[7:0]   : 8'd0;

  // --------------------------------------------------------------------------
  // Arbitration FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'b000;
      owner_q    <= 2'd0;
      last_q     <= 2'd2;
      brk_pend_q <= 1'b0;
      rd_valid_q <= 3'b000;
      rd_data_q  <= 32'd0;
`ifdef GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN
      cnt_q      <= 5'd0;
`endif
    end else if (iRESET_SYNC) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'b000;
      owner_q    <= 2'd0;
      last_q     <= 2'd2;
      brk_pend_q <= 1'b0;
      rd_valid_q <= 3'b000;
      rd_data_q  <= 32'd0;
`ifdef GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN
      cnt_q      <= 5'd0;
`endif
    end else begin
      rd_valid_q <= 3'b000;
      case (state_q)
        ST_IDLE: begin
          if (rr_hit) begin
            owner_q    <= rr_owner_d;
            grant_q    <= 3'b001 << rr_owner_d;
            brk_pend_q <= 1'b0;
            state_q    <= ST_REQ;
`ifdef GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN
            cnt_q      <= 5'd0;
`endif
          end
        end
        ST_REQ: begin
          if (iIF_ACK) begin
            state_q <= ST_WORK;
          end
        end
        ST_WORK: begin
          if (end_req) begin
            state_q <= ST_END;
          end else if (accept) begin
`ifdef GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN
            cnt_q <= cnt_q + 5'd1;
`endif
            if (!owner_rw) begin
              state_q <= ST_READ_WAIT;
            end
          end
        end
        ST_READ_WAIT: begin
          if (iIF_BREAK) begin
            brk_pend_q <= 1'b1;
          end
          if (iIF_VALID) begin
            rd_valid_q <= grant_q;
            rd_data_q  <= iIF_DATA;
            state_q    <= ST_WORK;
          end
        end
        ST_END: begin
          grant_q    <= 3'b000;
          last_q     <= owner_q;
          brk_pend_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gci_std_display_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gci_std_display_vram_arbiter
// Purpose  : Self-checking bench for gci_std_display_vram_arbiter. Expected
//            owners come from a round-robin rule model, and expected burst
//            splits come from a chunking model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gci_std_display_vram_arbiter;

  localparam int AW        = 23;
  localparam int BURST_MAX = 16;

  logic            clk;
  logic            rst_n;
  logic            sync_rst;
  logic [2:0]      rq_valid;
  logic [2:0]      rq_rw;
  logic [3*AW-1:0] rq_addr;
  logic [71:0]     rq_data;
  logic [2:0]      rq_finish;
  logic [2:0]      oRQ_GRANT;
  logic [2:0]      oRQ_BUSY;
  logic [2:0]      oRD_VALID;
  logic [31:0]     oRD_DATA;
  logic            oIF_REQ;
  logic            if_ack;
  logic            oIF_FINISH;
  logic            if_break;
  logic            if_busy;
  logic            oIF_ENA;
  logic            oIF_RW;
  logic [AW-1:0]   oIF_ADDR;
  logic [7:0]      oIF_R;
  logic [7:0]      oIF_G;
  logic [7:0]      oIF_B;
  logic            if_valid;
  logic [31:0]     if_data;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fin_cnt = 0;
  int rd_evt  = 0;
  int m_last  = 2;

  gci_std_display_vram_arbiter #(
    .P_MEM_ADDR_N (AW),
    .P_BURST_MAX  (BURST_MAX)
  ) u_dut (
    .iCLOCK      (clk),
    .inRESET     (rst_n),
    .iRESET_SYNC (sync_rst),
    .iRQ_VALID   (rq_valid),
    .iRQ_RW      (rq_rw),
    .iRQ_ADDR    (rq_addr),
    .iRQ_DATA    (rq_data),
    .iRQ_FINISH  (rq_finish),
    .oRQ_GRANT   (oRQ_GRANT),
    .oRQ_BUSY    (oRQ_BUSY),
    .oRD_VALID   (oRD_VALID),
    .oRD_DATA    (oRD_DATA),
    .oIF_REQ     (oIF_REQ),
    .iIF_ACK     (if_ack),
    .oIF_FINISH  (oIF_FINISH),
    .iIF_BREAK   (if_break),
    .iIF_BUSY    (if_busy),
    .oIF_ENA     (oIF_ENA),
    .oIF_RW      (oIF_RW),
    .oIF_ADDR    (oIF_ADDR),
    .oIF_R       (oIF_R),
    .oIF_G       (oIF_G),
    .oIF_B       (oIF_B),
    .iIF_VALID   (if_valid),
    .iIF_DATA    (if_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (oIF_FINISH) fin_cnt <= fin_cnt + 1;
    if (oRD_VALID != 3'b000) rd_evt <= rd_evt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  // Round-robin rule: first valid index searching from (last+1) mod 3.
  function automatic int rr_pick(input int last, input logic [2:0] mask);
    for (int k = 1; k <= 3; k++) begin
      if (mask[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the VRAM request, acknowledges it, leaves DUT in WORK.
  task automatic acquire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (oIF_REQ) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      if_ack = 1'b1;
      tick();
      if_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sync_rst = 1'b0; rq_valid = '0; rq_rw = '0; rq_addr = '0;
    rq_data = '0; rq_finish = '0; if_ack = 1'b0; if_break = 1'b0;
    if_busy = 1'b0; if_valid = 1'b0; if_data = '0;
    tick(); tick();
    vec_cnt++;
    if (oRQ_BUSY !== 3'b111 || oRQ_GRANT !== 3'b000 || oRD_VALID !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_rq: busy=%b grant=%b rdv=%b, expected 111/000/000", oRQ_BUSY, oRQ_GRANT, oRD_VALID);
    end
    vec_cnt++;
    if ({oIF_REQ, oIF_FINISH, oIF_ENA, oIF_RW} !== 4'b0000 || oIF_ADDR !== '0 ||
        {oIF_R, oIF_G, oIF_B} !== 24'd0 || oRD_DATA !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_if: req/fin/ena/rw=%b addr=%h rgb=%h rdd=%h, expected all zero",
               {oIF_REQ, oIF_FINISH, oIF_ENA, oIF_RW}, oIF_ADDR, {oIF_R, oIF_G, oIF_B}, oRD_DATA);
    end
    rst_n = 1'b1;
    m_last = 2;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp;
    int base;
    logic [AW-1:0] a;
    logic [23:0] d;
    base = fin_cnt;
    rq_valid = 3'b111;
    rq_rw    = 3'b111;
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 3; n++) begin
        rq_addr[n*AW +: AW] = AW'($urandom);
        rq_data[n*24 +: 24] = 24'($urandom);
      end
      acquire(ok);
      exp = rr_pick(m_last, 3'b111);
      vec_cnt++;
      if (!ok || oRQ_GRANT !== 3'(1 << exp)) begin
        err_cnt++;
        $display("FAIL rr_grant[%0d]: got %b ok=%0d, expected %b", g, oRQ_GRANT, ok, 3'(1 << exp));
      end
      if (g == 3) begin
        vec_cnt++;
        if (fin_cnt - base !== 3) begin
          err_cnt++;
          $display("FAIL rr_finish_count: got %0d, expected 3", fin_cnt - base);
        end
      end
      a = rq_addr[exp*AW +: AW];
      d = rq_data[exp*24 +: 24];
      rq_finish = ~(3'(1 << exp));  // non-owner finishes must be ignored
      #1;
      vec_cnt++;
      if (oIF_ENA !== 1'b1 || oIF_RW !== 1'b1 || oIF_ADDR !== a || {oIF_R, oIF_G, oIF_B} !== d ||
          oRQ_BUSY !== ~(3'(1 << exp))) begin
        err_cnt++;
        $display("FAIL rr_write[%0d]: ena=%b rw=%b addr=%h rgb=%h busy=%b, expected 1/1/%h/%h/%b",
                 g, oIF_ENA, oIF_RW, oIF_ADDR, {oIF_R, oIF_G, oIF_B}, oRQ_BUSY, a, d, ~(3'(1 << exp)));
      end
      tick();
      rq_finish = 3'(1 << exp);
      #1;
      vec_cnt++;
      if (oIF_ENA !== 1'b0) begin
        err_cnt++;
        $display("FAIL rr_finish_priority[%0d]: ena=%b, expected 0", g, oIF_ENA);
      end
      tick();
      vec_cnt++;
      if (oIF_FINISH !== 1'b1) begin
        err_cnt++;
        $display("FAIL rr_end[%0d]: finish=%b, expected 1", g, oIF_FINISH);
      end
      rq_finish = 3'b000;
      m_last = exp;
      if (g == 3) rq_valid = 3'b000;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp;
    logic [23:0] d;
    rq_valid = 3'b010;
    rq_rw    = 3'b111;
    acquire(ok);
    exp = rr_pick(m_last, 3'b010);
    vec_cnt++;
    if (!ok || oRQ_GRANT !== 3'(1 << exp)) begin
      err_cnt++;
      $display("FAIL b2b_grant: got %b ok=%0d, expected %b", oRQ_GRANT, ok, 3'(1 << exp));
    end
    rq_valid = 3'b111;  // other requesters' traffic must not leak
    for (int i = 0; i < 4; i++) begin
      rq_addr = {AW'($urandom), AW'('h10 + i), AW'($urandom)};
      rq_data = {24'($urandom), 24'($urandom), 24'($urandom)};
      d = rq_data[24 +: 24];
      #1;
      vec_cnt++;
      if (oIF_ENA !== 1'b1 || oIF_ADDR !== AW'('h10 + i) || {oIF_R, oIF_G, oIF_B} !== d) begin
        err_cnt++;
        $display("FAIL b2b_write[%0d]: ena=%b addr=%h rgb=%h, expected 1/%h/%h",
                 i, oIF_ENA, oIF_ADDR, {oIF_R, oIF_G, oIF_B}, AW'('h10 + i), d);
      end
      tick();
    end
    rq_valid = 3'b101;
    #1;
    vec_cnt++;
    if (oIF_ENA !== 1'b0 || oRQ_BUSY !== 3'b111) begin
      err_cnt++;
      $display("FAIL b2b_idle_owner: ena=%b busy=%b, expected 0/111", oIF_ENA, oRQ_BUSY);
    end
    rq_finish = 3'b010;
    tick();
    rq_finish = 3'b000;
    rq_valid  = 3'b000;
    m_last = exp;
    tick();
  endtask

  task automatic test_read();
    bit ok;
    int base;
    rq_valid = 3'b100;
    rq_rw    = 3'b000;
    rq_addr  = {AW'('h20), AW'($urandom), AW'($urandom)};
    acquire(ok);
    vec_cnt++;
    if (!ok || oRQ_GRANT !== 3'(1 << rr_pick(m_last, 3'b100))) begin
      err_cnt++;
      $display("FAIL read_grant: got %b ok=%0d, expected 100", oRQ_GRANT, ok);
    end
    base = rd_evt;
    vec_cnt++;
    if (oIF_ENA !== 1'b1 || oIF_RW !== 1'b0 || oIF_ADDR !== AW'('h20)) begin
      err_cnt++;
      $display("FAIL read_issue: ena=%b rw=%b addr=%h, expected 1/0/20", oIF_ENA, oIF_RW, oIF_ADDR);
    end
    tick();
    rq_valid = 3'b000;
    #1;
    vec_cnt++;
    if (oIF_ENA !== 1'b0 || oRQ_BUSY !== 3'b111) begin
      err_cnt++;
      $display("FAIL read_wait: ena=%b busy=%b, expected 0/111", oIF_ENA, oRQ_BUSY);
    end
    tick();
    tick();
    if_valid = 1'b1;
    if_data  = 32'hDEADBEEF;
    tick();
    if_valid = 1'b0;
    if_data  = 32'($urandom);
    vec_cnt++;
    if (oRD_VALID !== 3'b100 || oRD_DATA !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL read_return: rdv=%b data=%h, expected 100/deadbeef", oRD_VALID, oRD_DATA);
    end
    tick();
    vec_cnt++;
    if (oRD_VALID !== 3'b000 || rd_evt - base !== 1) begin
      err_cnt++;
      $display("FAIL read_pulse: rdv=%b pulses=%0d, expected 000/1", oRD_VALID, rd_evt - base);
    end
    rq_finish = 3'b100;
    tick();
    rq_finish = 3'b000;
    m_last = 2;
    tick();
  endtask

  task automatic test_break();
    bit ok;
    int exp;
    logic [2:0] mask;
    for (int r = 0; r < 3; r++) begin
      mask = 3'($urandom_range(1, 7));
      rq_valid = mask;
      rq_rw    = 3'($urandom);
      rq_addr  = {AW'($urandom), AW'($urandom), AW'($urandom)};
      acquire(ok);
      exp = rr_pick(m_last, mask);
      vec_cnt++;
      if (!ok || oRQ_GRANT !== 3'(1 << exp)) begin
        err_cnt++;
        $display("FAIL brk_grant[%0d]: got %b ok=%0d, expected %b", r, oRQ_GRANT, ok, 3'(1 << exp));
      end
      if_break = 1'b1;
      #1;
      vec_cnt++;
      if (oIF_ENA !== 1'b0) begin
        err_cnt++;
        $display("FAIL brk_no_ena[%0d]: ena=%b, expected 0", r, oIF_ENA);
      end
      tick();
      if_break = 1'b0;
      rq_valid = 3'b000;
      vec_cnt++;
      if (oIF_FINISH !== 1'b1) begin
        err_cnt++;
        $display("FAIL brk_end[%0d]: finish=%b, expected 1", r, oIF_FINISH);
      end
      tick();
      vec_cnt++;
      if (oRQ_GRANT !== 3'b000 || oIF_REQ !== 1'b0 || oIF_FINISH !== 1'b0) begin
        err_cnt++;
        $display("FAIL brk_idle[%0d]: grant=%b req=%b fin=%b, expected 000/0/0", r, oRQ_GRANT, oIF_REQ, oIF_FINISH);
      end
      m_last = exp;
    end
  endtask

  task automatic test_burst();
    int sent = 0;
    int cur  = 0;
    int sizes[$];
    int exp_sizes[$];
    int rem;
    int lim;
    bit done = 1'b0;
`ifdef GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN
    lim = BURST_MAX;
`else
    lim = 1000;
`endif
    rem = 20;
    while (rem > 0) begin
      exp_sizes.push_back((rem < lim) ? rem : lim);
      rem -= (rem < lim) ? rem : lim;
    end
    rq_rw = 3'b001;
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (sent == 20 && oRQ_GRANT == 3'b000) begin
        done = 1'b1;
        break;
      end
      rq_valid  = (sent < 20) ? 3'b001 : 3'b000;
      rq_addr[0 +: AW] = AW'('h100 + sent);
      rq_data   = {24'($urandom), 24'($urandom), 24'($urandom)};
      rq_finish = (sent == 20 && oRQ_GRANT[0]) ? 3'b001 : 3'b000;
      if_ack    = oIF_REQ;
      #1;
      if (oIF_ENA) begin
        vec_cnt++;
        if (oIF_ADDR !== AW'('h100 + sent)) begin
          err_cnt++;
          $display("FAIL burst_addr[%0d]: got %h, expected %h", sent, oIF_ADDR, AW'('h100 + sent));
        end
        sent++;
        cur++;
      end
      if (oIF_FINISH) begin
        sizes.push_back(cur);
        cur = 0;
      end
      @(posedge clk);
      #1;
    end
    if_ack = 1'b0;
    rq_finish = 3'b000;
    rq_valid = 3'b000;
    vec_cnt++;
    if (!done || sizes.size() != exp_sizes.size()) begin
      err_cnt++;
      $display("FAIL burst_grants: done=%0d grants=%0d, expected 1/%0d", done, sizes.size(), exp_sizes.size());
    end else begin
      foreach (exp_sizes[i]) begin
        vec_cnt++;
        if (sizes[i] != exp_sizes[i]) begin
          err_cnt++;
          $display("FAIL burst_size[%0d]: got %0d, expected %0d", i, sizes[i], exp_sizes[i]);
        end
      end
    end
    m_last = 0;
    tick();
  endtask

  task automatic test_sync_reset();
    bit ok;
    int base;
    int exp;
    rq_valid = 3'b001;
    rq_rw    = 3'b111;
    acquire(ok);
    vec_cnt++;
    if (!ok || oRQ_GRANT !== 3'b001) begin
      err_cnt++;
      $display("FAIL sync_pre_grant: got %b ok=%0d, expected 001", oRQ_GRANT, ok);
    end
    base = fin_cnt;
    sync_rst = 1'b1;
    rq_valid = 3'b000;
    tick();
    sync_rst = 1'b0;
    vec_cnt++;
    if (oRQ_GRANT !== 3'b000 || oRQ_BUSY !== 3'b111 || oIF_FINISH !== 1'b0 || oIF_REQ !== 1'b0) begin
      err_cnt++;
      $display("FAIL sync_reset: grant=%b busy=%b fin=%b req=%b, expected 000/111/0/0",
               oRQ_GRANT, oRQ_BUSY, oIF_FINISH, oIF_REQ);
    end
    m_last = 2;
    tick();
    vec_cnt++;
    if (fin_cnt != base) begin
      err_cnt++;
      $display("FAIL sync_no_finish: pulses=%0d, expected 0", fin_cnt - base);
    end
    rq_valid = 3'b011;
    acquire(ok);
    exp = rr_pick(m_last, 3'b011);
    vec_cnt++;
    if (!ok || oRQ_GRANT !== 3'(1 << exp)) begin
      err_cnt++;
      $display("FAIL sync_last_owner: got %b ok=%0d, expected %b", oRQ_GRANT, ok, 3'(1 << exp));
    end
    rq_finish = 3'(1 << exp);
    rq_valid  = 3'b000;
    tick();
    rq_finish = 3'b000;
    m_last = exp;
    tick();
  endtask

  task automatic test_reset_in_read();
    bit ok;
    int o;
    int rbase;
    int fbase;
    o = $urandom_range(0, 2);
    rq_valid = 3'(1 << o);
    rq_rw    = 3'b000;
    rq_addr  = {AW'($urandom), AW'($urandom), AW'($urandom)};
    acquire(ok);
    vec_cnt++;
    if (!ok || oIF_ENA !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstrd_issue: ok=%0d ena=%b, expected 1/1", ok, oIF_ENA);
    end
    tick();
    rq_valid = 3'b000;
    rbase = rd_evt;
    fbase = fin_cnt;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (oRQ_BUSY !== 3'b111 || oRQ_GRANT !== 3'b000 || oIF_ENA !== 1'b0) begin
      err_cnt++;
      $display("FAIL rstrd_async: busy=%b grant=%b ena=%b, expected 111/000/0", oRQ_BUSY, oRQ_GRANT, oIF_ENA);
    end
    tick();
    rst_n = 1'b1;
    m_last = 2;
    if_valid = 1'b1;
    if_data  = 32'($urandom);
    tick();
    if_valid = 1'b0;
    tick();
    vec_cnt++;
    if (oRD_VALID !== 3'b000 || rd_evt != rbase || oRQ_BUSY !== 3'b111 || fin_cnt != fbase) begin
      err_cnt++;
      $display("FAIL rstrd_discard: rdv=%b pulses=%0d busy=%b fins=%0d, expected 000/0/111/0",
               oRD_VALID, rd_evt - rbase, oRQ_BUSY, fin_cnt - fbase);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_read();
    test_break();
    test_burst();
    test_sync_reset();
    test_reset_in_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gci_std_display_vram_arbiter.md
GCI_STD_DISPLAY_VRAM_ARBITER -- requirements
Module: gci_std_display_vram_arbiter

Interface
REQ-001 The block SHALL have parameter P_MEM_ADDR_N, default 23, giving the VRAM interface address width.
REQ-002 The block SHALL have parameter P_BURST_MAX, default 16, giving the maximum transfers per grant (used only under REQ-030).
REQ-003 The block SHALL have port iCLOCK, input, 1 bit: clock.
REQ-004 The block SHALL have port inRESET, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port iRESET_SYNC, input, 1 bit: synchronous reset, active-high.
REQ-006 The block SHALL have port iRQ_VALID, input, 3 bits: per-requester transfer valid (0=clear, 1=character, 2=bus).
REQ-007 The block SHALL have port iRQ_RW, input, 3 bits: per-requester direction, 1=write, 0=read.
REQ-008 The block SHALL have port iRQ_ADDR, input, 3*P_MEM_ADDR_N bits: per-requester address, requester n at slice n.
REQ-009 The block SHALL have port iRQ_DATA, input, 72 bits: per-requester {R,G,B} write data, 24 bits each, requester n at slice n.
REQ-010 The block SHALL have port iRQ_FINISH, input, 3 bits: requester releases its grant.
REQ-011 The block SHALL have ports oRQ_GRANT, output, 3 bits (one-hot owner), and oRQ_BUSY, output, 3 bits (transfer not accepted this cycle).
REQ-012 The block SHALL have ports oRD_VALID, output, 3 bits, and oRD_DATA, output, 32 bits: read return routed to the owner.
REQ-013 The block SHALL have the VRAM-side ports oIF_REQ out 1, iIF_ACK in 1, oIF_FINISH out 1, iIF_BREAK in 1, iIF_BUSY in 1, oIF_ENA out 1, oIF_RW out 1, oIF_ADDR out P_MEM_ADDR_N, oIF_R/oIF_G/oIF_B out 8 each, iIF_VALID in 1, and iIF_DATA in 32.

Function
REQ-014 The block SHALL implement the states IDLE, REQ, WORK, READ_WAIT and END.
REQ-015 In IDLE with any iRQ_VALID bit set, the block SHALL choose an owner round-robin, searching from (last owner+1) mod 3, register it into oRQ_GRANT and go to REQ; the last owner after reset is 2.
REQ-016 In REQ the block SHALL hold oIF_REQ=1 and move to WORK on the cycle after iIF_ACK=1.
REQ-017 In WORK, iIF_BREAK=1 or iRQ_FINISH[owner]=1 SHALL move the block to END, and this check SHALL take priority over any transfer that cycle.
REQ-018 Otherwise in WORK, when iRQ_VALID[owner]=1 and iIF_BUSY=0, the block SHALL drive oIF_ENA=1 combinationally with oIF_RW, oIF_ADDR and RGB taken from the owner's slice, and drive oRQ_BUSY[owner]=0 (accept).
REQ-019 An accepted read SHALL move the block to READ_WAIT; an accepted write SHALL keep it in WORK, giving back-to-back writes at 1 per cycle.
REQ-020 In READ_WAIT, on iIF_VALID=1 the block SHALL pulse oRD_VALID[owner]=1 for 1 cycle with oRD_DATA=iIF_DATA and return to WORK; iIF_BREAK SHALL be deferred until that return.
REQ-021 In END the block SHALL pulse oIF_FINISH=1 for 1 cycle, clear oRQ_GRANT, record the last owner and go to IDLE.
REQ-022 Non-owners SHALL see oRQ_BUSY=1 at all times, and the owner SHALL see oRQ_BUSY=1 whenever a transfer is not accepted.
REQ-023 oIF_ENA SHALL be 0 outside WORK.
REQ-024 iRQ_VALID from a non-owner SHALL never reach the VRAM-side ports.
REQ-025 iRQ_FINISH from a non-owner SHALL be ignored.

Reset
REQ-026 On inRESET=0 the block SHALL be in IDLE with all outputs 0 except oRQ_BUSY=3'b111, and the last owner SHALL be 2.
REQ-027 iRESET_SYNC=1 SHALL give the same values as REQ-026 on the next edge, from any state.
REQ-028 A reset during READ_WAIT SHALL discard the pending read, so no oRD_VALID occurs after reset.
REQ-029 Reset SHALL NOT pulse oIF_FINISH.

Configuration
REQ-030 With GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN defined, a 5-bit transfer counter SHALL clear on grant and increment per accepted transfer, and reaching P_BURST_MAX SHALL force WORK->END, as an iRQ_FINISH would.
REQ-031 Without GCI_STD_DISPLAY_VRAM_ARB_BURST_LIMIT_EN, no counter SHALL exist and a grant SHALL last until iRQ_FINISH or iIF_BREAK.

Verification
REQ-032 The bench SHALL cover: iRQ_VALID=3'b111 held with FINISH after 1 write each -> grants in order 0,1,2,0; oIF_FINISH pulses 3 times.
REQ-033 The bench SHALL cover: owner 1 issues 4 writes, addr 0x10..0x13, iIF_BUSY=0 -> oIF_ENA high 4 consecutive cycles with matching oIF_ADDR.
REQ-034 The bench SHALL cover: owner 2 reads addr 0x20, iIF_VALID 3 cycles later with data 0xDEADBEEF -> oRD_VALID=3'b100 with that data, and no other oRD_VALID.
REQ-035 The bench SHALL cover: iIF_BREAK in WORK with iRQ_VALID=1 -> no oIF_ENA that cycle, END, then IDLE.
REQ-036 The bench SHALL cover: inRESET=0 in READ_WAIT, then iIF_VALID=1 -> oRD_VALID stays 0 and oRQ_BUSY=3'b111.
REQ-037 The bench SHALL cover, with the macro defined and P_BURST_MAX=16: 20 continuous writes -> release after 16, re-grant, then 4 more.
